heap_pq: RTL and testbench
==========================

HEAP_PQ -- requirements
Module: heap_pq

Interface
REQ-001 SHALL have parameter DATA_W, default 32, key width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, maximum entries (power of two, 4..1024).
REQ-003 SHALL have parameter MIN_HEAP, default 0: 0 means a larger key has higher priority; 1 means a smaller key has higher priority.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- op_valid  in  1  operation request.
- op_ready  out  1  block idle and able to accept.
- op_code  in  2  0=PUSH, 1=POP, 2=CLEAR, 3=REPLACE.
- op_data  in  DATA_W  key for PUSH/REPLACE.
- res_valid  out  1  one-cycle pulse, res_data valid.
- res_data  out  DATA_W  key removed by POP/REPLACE.
- top_valid  out  1  top_data is the current highest-priority key.
- top_data  out  DATA_W  root entry.
- count  out  $clog2(DEPTH+1)  entries held.
- full, empty  out  1  count==DEPTH, count==0.
- err  out  1  one-cycle pulse on a rejected operation.

Function
REQ-005 An operation SHALL be accepted only in a cycle where op_valid and op_ready are both 1.
REQ-006 The FSM SHALL have states IDLE, SIFT_UP and SIFT_DOWN; op_ready SHALL be 1 only in IDLE.
REQ-007 PUSH when not full SHALL write op_data at index count, increment count on the accept edge, and enter SIFT_UP at that index.
REQ-008 SIFT_UP SHALL perform one node-versus-parent compare per cycle.
- Swap only on strictly higher priority, then move to the parent.
- Return to IDLE at the root or on no swap.
REQ-009 POP when not empty SHALL, on the cycle after accept:
- drive res_data with the old root and pulse res_valid;
- move the last entry to the root and decrement count;
- enter SIFT_DOWN, or IDLE if count becomes 0 or 1.
REQ-010 SIFT_DOWN SHALL perform one level per cycle.
- Select the higher-priority child; on a tie, select the left child.
- Swap only if the child is strictly higher priority than the node.
- Return to IDLE at a leaf or on no swap.
REQ-011 REPLACE when not empty SHALL return the old root as POP does, write op_data to the root with count unchanged, and enter SIFT_DOWN.
REQ-012 REPLACE when empty SHALL behave exactly as PUSH.
REQ-013 CLEAR SHALL set count to 0 in one cycle and remain in IDLE, with no res_valid pulse.
REQ-014 PUSH when full, or POP when empty, SHALL be accepted with no state change and SHALL pulse err the following cycle.
REQ-015 top_valid SHALL equal (state==IDLE && !empty); top_data SHALL be the root entry.
REQ-016 Worst-case accept-to-op_ready latency SHALL be 1+log2(DEPTH) cycles.
REQ-017 Storage SHALL be a register array; compares SHALL be unsigned at DATA_W bits.

Reset
REQ-018 With reset high at a clk edge, the block SHALL enter IDLE with:
- count=0, empty=1, full=0, op_ready=1;
- res_valid=0, err=0, top_valid=0, res_data=0.
REQ-019 Reset during SIFT_UP or SIFT_DOWN SHALL abandon the operation; storage contents need not be cleared.

Configuration
REQ-020 Macro HEAP_PQ_REPLACE_EN SHALL control the REPLACE operation.
- Defined: REPLACE behaves per REQ-011 and REQ-012.
- Undefined: op_code 3 is accepted with no state change and pulses err; REPLACE logic is not synthesised.

Structure
REQ-021 Package heap_pq_pkg SHALL hold:
- the op-code enum;
- the FSM state enum;
- the parent and child index helper functions.
REQ-022 Storage with its two-write-port swap SHALL be sub-module heap_pq_store; the compare and FSM SHALL stay in heap_pq.

Verification
REQ-023 Push 5, 9, 1, 7 into a max-heap with DEPTH=8 -> top_data=9, count=4; four POPs -> res_data 9, 7, 5, 1, then empty=1.
REQ-024 MIN_HEAP=1: push 0x30, 0x10, 0x20 -> top_data=0x10; POP -> res_data=0x10, top_data=0x20.
REQ-025 Fill to DEPTH=8, then PUSH -> err pulse, count stays 8; POP when empty -> err pulse, no res_valid.
REQ-026 Push 1..8 in ascending order into a max-heap -> last PUSH has op_ready low for at most 4 cycles; top_data=8.
REQ-027 REPLACE 3 on heap {9, 5} (macro defined) -> res_data=9, top_data=5, count=2; assert reset mid-SIFT_DOWN -> next cycle count=0, op_ready=1.

Source files
------------

// File: rtl/heap_pq_pkg.sv
// Shared types and heap index helpers for the heap priority queue.
// Indices are zero-based: root at 0, children of i at 2i+1 and 2i+2.
package heap_pq_pkg;

    typedef enum logic [1:0] {
        OP_PUSH    = 2'd0,
        OP_POP     = 2'd1,
        OP_CLEAR   = 2'd2,
        OP_REPLACE = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SIFT_UP   = 2'd1,
        ST_SIFT_DOWN = 2'd2
    } state_e;

    // Meaningless for the root; callers must check for index 0 first.
    function automatic int unsigned parent_idx(input int unsigned i);
        return (i - 1) >> 1;
    endfunction

    function automatic int unsigned left_idx(input int unsigned i);
        return 2 * i + 1;
    endfunction

    function automatic int unsigned right_idx(input int unsigned i);
        return 2 * i + 2;
    endfunction

endpackage

// File: rtl/heap_pq_store.sv
// Heap entry storage: register array with two independent write ports so a
// node and its parent/child can be swapped in a single cycle, plus three
// combinational read ports and a dedicated root read.
// Contents are deliberately not reset; count in the controller defines validity.
module heap_pq_store
    import heap_pq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_a,
    input  logic [IDX_W-1:0]  addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic              we_b,
    input  logic [IDX_W-1:0]  addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    input  logic [IDX_W-1:0]  raddr_a,
    input  logic [IDX_W-1:0]  raddr_b,
    input  logic [IDX_W-1:0]  raddr_c,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic [DATA_W-1:0] rdata_c,
    output logic [DATA_W-1:0] root_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Both ports write in the same edge; the controller never aims them at one index.
    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= wdata_a;
        if (we_b) mem[addr_b] <= wdata_b;
    end

    assign rdata_a   = mem[raddr_a];
    assign rdata_b   = mem[raddr_b];
    assign rdata_c   = mem[raddr_c];
    assign root_data = mem[0];

endmodule

// File: rtl/heap_pq.sv
// Binary-heap priority queue controller: PUSH / POP / CLEAR / REPLACE with
// one compare level per cycle.
// Build option: define HEAP_PQ_REPLACE_EN to enable REPLACE; without it,
// op_code 3 is rejected with an err pulse.
//
// state        | meaning
// -------------+------------------------------------------------------------
// ST_IDLE      | accepting operations; root is valid when count != 0
// ST_SIFT_UP   | new entry at cur climbing toward the root
// ST_SIFT_DOWN | entry at cur sinking toward the leaves after POP/REPLACE
module heap_pq
    import heap_pq_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int MIN_HEAP = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       op_valid,
    output logic                       op_ready,
    input  logic [1:0]                 op_code,
    input  logic [DATA_W-1:0]          op_data,
    output logic                       res_valid,
    output logic [DATA_W-1:0]          res_data,
    output logic                       top_valid,
    output logic [DATA_W-1:0]          top_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    state_e            state, state_nxt;
    logic [CNT_W-1:0]  count_nxt;
    logic [IDX_W-1:0]  cur, cur_nxt;
    logic              res_valid_nxt;
    logic [DATA_W-1:0] res_data_nxt;
    logic              err_nxt;

    logic              we_a, we_b;
    logic [IDX_W-1:0]  addr_a, addr_b;
    logic [DATA_W-1:0] wdata_a, wdata_b;
    logic [IDX_W-1:0]  raddr_a, raddr_b, raddr_c;
    logic [DATA_W-1:0] rdata_a, rdata_b, rdata_c, root_data;

    int unsigned       p_i, l_i, r_i, child_i;
    logic              child_right;
    logic [DATA_W-1:0] child_data;
    logic [IDX_W-1:0]  last_idx;
    op_e               op;
    logic              do_push, do_pop, do_repl;

    // True when a must sit above b in the heap (strict, so ties never swap).
    function automatic logic higher(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (MIN_HEAP != 0) return a < b;
        else               return a > b;
    endfunction

    heap_pq_store #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_store (
        .clk       (clk),
        .we_a      (we_a),
        .addr_a    (addr_a),
        .wdata_a   (wdata_a),
        .we_b      (we_b),
        .addr_b    (addr_b),
        .wdata_b   (wdata_b),
        .raddr_a   (raddr_a),
        .raddr_b   (raddr_b),
        .raddr_c   (raddr_c),
        .rdata_a   (rdata_a),
        .rdata_b   (rdata_b),
        .rdata_c   (rdata_c),
        .root_data (root_data)
    );

    assign op_ready  = (state == ST_IDLE);
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign top_valid = op_ready && !empty;
    assign top_data  = root_data;
    assign last_idx  = IDX_W'(count - CNT_W'(1));

    // Next-state, storage write and result decode for every state.
    always_comb begin
        state_nxt     = state;
        count_nxt     = count;
        cur_nxt       = cur;
        res_valid_nxt = 1'b0;
        res_data_nxt  = res_data;
        err_nxt       = 1'b0;
        we_a          = 1'b0;
        addr_a        = '0;
        wdata_a       = '0;
        we_b          = 1'b0;
        addr_b        = '0;
        wdata_b       = '0;
        raddr_a       = cur;
        raddr_b       = '0;
        raddr_c       = '0;
        p_i           = parent_idx(32'(cur));
        l_i           = left_idx(32'(cur));
        r_i           = right_idx(32'(cur));
        child_right   = 1'b0;
        child_data    = '0;
        child_i       = 0;
        op            = op_e'(op_code);
        do_push       = 1'b0;
        do_pop        = 1'b0;
        do_repl       = 1'b0;

        unique case (state)
            ST_IDLE: begin
                raddr_b = last_idx;
                if (op_valid) begin
                    unique case (op)
                        OP_PUSH: begin
                            if (full) err_nxt = 1'b1;
                            else      do_push = 1'b1;
                        end
                        OP_POP: begin
                            if (empty) err_nxt = 1'b1;
                            else       do_pop  = 1'b1;
                        end
                        OP_CLEAR: count_nxt = '0;
                        OP_REPLACE: begin
`ifdef HEAP_PQ_REPLACE_EN
                            if (empty) do_push = 1'b1;
                            else       do_repl = 1'b1;
`else
                            err_nxt = 1'b1;
`endif
                        end
                        default: ;
                    endcase
                end

                if (do_push) begin
                    we_a      = 1'b1;
                    addr_a    = IDX_W'(count);
                    wdata_a   = op_data;
                    count_nxt = count + CNT_W'(1);
                    cur_nxt   = IDX_W'(count);
                    state_nxt = ST_SIFT_UP;
                end
                if (do_pop || do_repl) begin
                    res_valid_nxt = 1'b1;
                    res_data_nxt  = root_data;
                    we_a          = 1'b1;
                    addr_a        = '0;
                    cur_nxt       = '0;
                end
                if (do_pop) begin
                    wdata_a   = rdata_b;
                    count_nxt = count - CNT_W'(1);
                    state_nxt = (count <= CNT_W'(2)) ? ST_IDLE : ST_SIFT_DOWN;
                end
                if (do_repl) begin
                    wdata_a   = op_data;
                    state_nxt = ST_SIFT_DOWN;
                end
            end

            ST_SIFT_UP: begin
                raddr_b = IDX_W'(p_i);
                if (cur == '0) begin
                    state_nxt = ST_IDLE;
                end else if (higher(rdata_a, rdata_b)) begin
                    we_a    = 1'b1;
                    addr_a  = cur;
                    wdata_a = rdata_b;
                    we_b    = 1'b1;
                    addr_b  = IDX_W'(p_i);
                    wdata_b = rdata_a;
                    // Landing on the root needs no further compare.
                    if (p_i == 0) state_nxt = ST_IDLE;
                    else          cur_nxt   = IDX_W'(p_i);
                end else begin
                    state_nxt = ST_IDLE;
                end
            end

            ST_SIFT_DOWN: begin
                raddr_b     = IDX_W'(l_i);
                raddr_c     = IDX_W'(r_i);
                child_right = (r_i < 32'(count)) && higher(rdata_c, rdata_b);
                child_data  = child_right ? rdata_c : rdata_b;
                child_i     = child_right ? r_i : l_i;
                if (l_i >= 32'(count)) begin
                    state_nxt = ST_IDLE;
                end else if (higher(child_data, rdata_a)) begin
                    we_a      = 1'b1;
                    addr_a    = cur;
                    wdata_a   = child_data;
                    we_b      = 1'b1;
                    addr_b    = IDX_W'(child_i);
                    wdata_b   = rdata_a;
                    cur_nxt   = IDX_W'(child_i);
                end else begin
                    state_nxt = ST_IDLE;
                end
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Occupancy, sift cursor and result/err pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            cur       <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            err       <= 1'b0;
        end else begin
            count     <= count_nxt;
            cur       <= cur_nxt;
            res_valid <= res_valid_nxt;
            res_data  <= res_data_nxt;
            err       <= err_nxt;
        end
    end

endmodule

// File: tb/tb_heap_pq.sv
// Self-checking bench for heap_pq: table vectors, corner sequences and a
// randomized run against a queue-based reference model.
module tb_heap_pq;
    import heap_pq_pkg::*;

    localparam int DW  = 16;
    localparam int DEP = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          op_valid  [2];
    logic          op_ready  [2];
    logic [1:0]    op_code   [2];
    logic [DW-1:0] op_data   [2];
    logic          res_valid [2];
    logic [DW-1:0] res_data  [2];
    logic          top_valid [2];
    logic [DW-1:0] top_data  [2];
    logic [3:0]    count     [2];
    logic          full      [2];
    logic          empty     [2];
    logic          err       [2];

    int vec_cnt     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    heap_pq #(.DATA_W(DW), .DEPTH(DEP), .MIN_HEAP(0)) u_max (
        .clk(clk), .reset(reset),
        .op_valid(op_valid[0]), .op_ready(op_ready[0]), .op_code(op_code[0]), .op_data(op_data[0]),
        .res_valid(res_valid[0]), .res_data(res_data[0]), .top_valid(top_valid[0]), .top_data(top_data[0]),
        .count(count[0]), .full(full[0]), .empty(empty[0]), .err(err[0])
    );

    heap_pq #(.DATA_W(DW), .DEPTH(DEP), .MIN_HEAP(1)) u_min (
        .clk(clk), .reset(reset),
        .op_valid(op_valid[1]), .op_ready(op_ready[1]), .op_code(op_code[1]), .op_data(op_data[1]),
        .res_valid(res_valid[1]), .res_data(res_data[1]), .top_valid(top_valid[1]), .top_data(top_data[1]),
        .count(count[1]), .full(full[1]), .empty(empty[1]), .err(err[1])
    );

    typedef struct {
        logic [1:0]    code;
        logic [DW-1:0] data;
        logic          rv;
        logic [DW-1:0] rd;
        logic          er;
        logic [3:0]    cnt;
        logic          tv;
        logic [DW-1:0] top;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Issue one op on DUT d, capture the pulses the cycle after accept,
    // then wait (bounded) for op_ready; busy = cycles op_ready was low.
    task automatic run_op(input int d, input logic [1:0] code, input logic [DW-1:0] data,
                          output logic rv, output logic [DW-1:0] rd, output logic er, output int busy);
        int guard;
        guard = 0;
        while (!op_ready[d] && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!op_ready[d]) check("ready_before_op", 32'(op_ready[d]), 1);
        op_valid[d] = 1'b1;
        op_code[d]  = code;
        op_data[d]  = data;
        @(posedge clk); #1;
        op_valid[d] = 1'b0;
        rv = res_valid[d];
        rd = res_data[d];
        er = err[d];
        busy = 0;
        while (!op_ready[d] && busy < 50) begin
            @(posedge clk); #1;
            busy++;
        end
        if (!op_ready[d]) check("op_done_timeout", 32'(op_ready[d]), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          rv, er;
        logic [DW-1:0] rd;
        int            busy;
        int            q[$];

        for (int d = 0; d < 2; d++) begin
            op_valid[d] = 1'b0;
            op_code[d]  = 2'd0;
            op_data[d]  = '0;
        end

        tbl[0]  = '{OP_PUSH,  16'd5, 1'b0, 16'd0, 1'b0, 4'd1, 1'b1, 16'd5};
        tbl[1]  = '{OP_PUSH,  16'd9, 1'b0, 16'd0, 1'b0, 4'd2, 1'b1, 16'd9};
        tbl[2]  = '{OP_PUSH,  16'd1, 1'b0, 16'd0, 1'b0, 4'd3, 1'b1, 16'd9};
        tbl[3]  = '{OP_PUSH,  16'd7, 1'b0, 16'd0, 1'b0, 4'd4, 1'b1, 16'd9};
        tbl[4]  = '{OP_POP,   16'd0, 1'b1, 16'd9, 1'b0, 4'd3, 1'b1, 16'd7};
        tbl[5]  = '{OP_POP,   16'd0, 1'b1, 16'd7, 1'b0, 4'd2, 1'b1, 16'd5};
        tbl[6]  = '{OP_POP,   16'd0, 1'b1, 16'd5, 1'b0, 4'd1, 1'b1, 16'd1};
        tbl[7]  = '{OP_POP,   16'd0, 1'b1, 16'd1, 1'b0, 4'd0, 1'b0, 16'd0};
        tbl[8]  = '{OP_POP,   16'd0, 1'b0, 16'd0, 1'b1, 4'd0, 1'b0, 16'd0};
        tbl[9]  = '{OP_PUSH,  16'd3, 1'b0, 16'd0, 1'b0, 4'd1, 1'b1, 16'd3};
        tbl[10] = '{OP_PUSH,  16'd3, 1'b0, 16'd0, 1'b0, 4'd2, 1'b1, 16'd3};
        tbl[11] = '{OP_CLEAR, 16'd0, 1'b0, 16'd0, 1'b0, 4'd0, 1'b0, 16'd0};

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_count",     32'(count[0]),     0);
        check("rst_empty",     32'(empty[0]),     1);
        check("rst_full",      32'(full[0]),      0);
        check("rst_op_ready",  32'(op_ready[0]),  1);
        check("rst_res_valid", 32'(res_valid[0]), 0);
        check("rst_err",       32'(err[0]),       0);
        check("rst_top_valid", 32'(top_valid[0]), 0);
        check("rst_res_data",  32'(res_data[0]),  0);

        for (int i = 0; i < 12; i++) begin
            run_op(0, tbl[i].code, tbl[i].data, rv, rd, er, busy);
            check($sformatf("tbl%0d_res_valid", i), 32'(rv), 32'(tbl[i].rv));
            if (tbl[i].rv) check($sformatf("tbl%0d_res_data", i), 32'(rd), 32'(tbl[i].rd));
            check($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].er));
            check($sformatf("tbl%0d_count", i), 32'(count[0]), 32'(tbl[i].cnt));
            check($sformatf("tbl%0d_top_valid", i), 32'(top_valid[0]), 32'(tbl[i].tv));
            if (tbl[i].tv) check($sformatf("tbl%0d_top_data", i), 32'(top_data[0]), 32'(tbl[i].top));
        end

        // Min-heap ordering.
        run_op(1, OP_PUSH, 16'h30, rv, rd, er, busy);
        run_op(1, OP_PUSH, 16'h10, rv, rd, er, busy);
        run_op(1, OP_PUSH, 16'h20, rv, rd, er, busy);
        check("min_top_after_push", 32'(top_data[1]), 32'h10);
        check("min_count", 32'(count[1]), 3);
        run_op(1, OP_POP, 16'h0, rv, rd, er, busy);
        check("min_pop_valid", 32'(rv), 1);
        check("min_pop_data", 32'(rd), 32'h10);
        check("min_pop_err", 32'(er), 0);
        check("min_top_after_pop", 32'(top_data[1]), 32'h20);
        check("min_top_valid", 32'(top_valid[1]), 1);
        check("min_full", 32'(full[1]), 0);
        check("min_empty", 32'(empty[1]), 0);

        // Ascending fill: the last push climbs the full height.
        do_reset();
        for (int k = 1; k <= 8; k++) run_op(0, OP_PUSH, 16'(k), rv, rd, er, busy);
        check("push8_busy_le4", 32'(busy <= 4), 1);
        check("fill_top", 32'(top_data[0]), 8);
        check("fill_count", 32'(count[0]), 8);
        check("fill_full", 32'(full[0]), 1);
        run_op(0, OP_PUSH, 16'd99, rv, rd, er, busy);
        check("push_full_err", 32'(er), 1);
        check("push_full_no_res", 32'(rv), 0);
        check("push_full_count", 32'(count[0]), 8);
        check("push_full_top", 32'(top_data[0]), 8);

        // Reset while a POP is sifting down.
        op_valid[0] = 1'b1;
        op_code[0]  = OP_POP;
        @(posedge clk); #1;
        op_valid[0] = 1'b0;
        check("midpop_res_valid", 32'(res_valid[0]), 1);
        check("midpop_res_data", 32'(res_data[0]), 8);
        check("midpop_busy", 32'(op_ready[0]), 0);
        do_reset();
        check("midpop_rst_count", 32'(count[0]), 0);
        check("midpop_rst_ready", 32'(op_ready[0]), 1);
        check("midpop_rst_empty", 32'(empty[0]), 1);
        check("midpop_rst_top_valid", 32'(top_valid[0]), 0);
        check("midpop_rst_res_data", 32'(res_data[0]), 0);

        run_op(0, OP_PUSH, 16'd9, rv, rd, er, busy);
        run_op(0, OP_PUSH, 16'd5, rv, rd, er, busy);
`ifdef HEAP_PQ_REPLACE_EN
        run_op(0, OP_REPLACE, 16'd3, rv, rd, er, busy);
        check("repl_res_valid", 32'(rv), 1);
        check("repl_res_data", 32'(rd), 9);
        check("repl_err", 32'(er), 0);
        check("repl_top", 32'(top_data[0]), 5);
        check("repl_count", 32'(count[0]), 2);
        op_valid[0] = 1'b1;
        op_code[0]  = OP_REPLACE;
        op_data[0]  = 16'd1;
        @(posedge clk); #1;
        op_valid[0] = 1'b0;
        check("midrepl_busy", 32'(op_ready[0]), 0);
        do_reset();
        check("midrepl_rst_count", 32'(count[0]), 0);
        check("midrepl_rst_ready", 32'(op_ready[0]), 1);
`else
        run_op(0, OP_REPLACE, 16'd3, rv, rd, er, busy);
        check("repl_off_err", 32'(er), 1);
        check("repl_off_no_res", 32'(rv), 0);
        check("repl_off_count", 32'(count[0]), 2);
        check("repl_off_top", 32'(top_data[0]), 9);
`endif

        // Randomized run against a queue model of the max-heap.
        do_reset();
        q.delete();
        for (int n = 0; n < 400; n++) begin
            int            r, mi;
            logic [1:0]    code;
            logic [DW-1:0] data;
            logic          exp_rv, exp_er;
            logic [DW-1:0] exp_rd;
            r    = int'($urandom_range(0, 99));
            data = 16'($urandom_range(0, 40));
            code = (r < 55) ? OP_PUSH : (r < 94) ? OP_POP : OP_CLEAR;
            exp_rv = 1'b0;
            exp_er = 1'b0;
            exp_rd = '0;
            if (code == OP_PUSH) begin
                if (q.size() == DEP) exp_er = 1'b1;
                else                 q.push_back(int'(data));
            end else if (code == OP_POP) begin
                if (q.size() == 0) exp_er = 1'b1;
                else begin
                    mi = 0;
                    for (int j = 1; j < q.size(); j++) if (q[j] > q[mi]) mi = j;
                    exp_rv = 1'b1;
                    exp_rd = DW'(q[mi]);
                    q.delete(mi);
                end
            end else begin
                q.delete();
            end
            run_op(0, code, data, rv, rd, er, busy);
            check($sformatf("rnd%0d_res_valid", n), 32'(rv), 32'(exp_rv));
            if (exp_rv) check($sformatf("rnd%0d_res_data", n), 32'(rd), 32'(exp_rd));
            check($sformatf("rnd%0d_err", n), 32'(er), 32'(exp_er));
            check($sformatf("rnd%0d_count", n), 32'(count[0]), 32'(q.size()));
            check($sformatf("rnd%0d_top_valid", n), 32'(top_valid[0]), 32'(q.size() != 0));
            if (q.size() != 0) begin
                mi = 0;
                for (int j = 1; j < q.size(); j++) if (q[j] > q[mi]) mi = j;
                check($sformatf("rnd%0d_top_data", n), 32'(top_data[0]), 32'(q[mi]));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
